l1_mem_arbiter: RTL and testbench
=================================

Name: l1_mem_arbiter

Overview:
- Shares one lower-memory port between the L1 data cache (port D) and the L1 instruction cache (port I).
- Each cache-side port uses the same level-held request protocol as the cache's lower-memory interface: request, write enable, address, write data, response data, ready.
- The block serialises transactions, one in flight at a time. Fixed D priority is bounded by an I-starvation limit.
- Sits between both L1 caches and the L2/memory interface.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- STARVE_LIMIT, 4, number of consecutive D grants allowed while I is waiting before I is forced; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_req  in  1  D-cache request, held until d_ready.
- d_we  in  1  D write enable (1=write, 0=read).
- d_addr  in  ADDR_WIDTH  D address.
- d_wdata  in  DATA_WIDTH  D write data.
- d_rdata  out  DATA_WIDTH  D read response, registered.
- d_ready  out  1  D completion, one-cycle pulse.
- i_req, i_we, i_addr, i_wdata, i_rdata, i_ready  same as the D equivalents, for the I-cache.
- mem_request  out  1  lower-memory request, held until mem_ready.
- mem_write_enable  out  1  lower-memory write enable.
- mem_address  out  ADDR_WIDTH  lower-memory address.
- mem_write_data  out  DATA_WIDTH  lower-memory write data.
- mem_response_data  in  DATA_WIDTH  lower-memory read data, valid with mem_ready.
- mem_ready  in  1  lower-memory completion.
- grant_owner  out  1  current/last owner (0=D, 1=I).
- arb_state  out  2  state encoding: 0=IDLE, 1=ISSUE, 2=RESP.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; every output=0, including d_rdata/i_rdata; starve counter=0; grant_owner=0.
  - Reset mid-transaction drops mem_request on the next edge; the in-flight transaction is abandoned and no ready pulse is issued.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- IDLE, with no request: stay in IDLE; mem_request=0.
- IDLE, with any request:
  - Select the winner: only one requesting -> that one.
  - Both requesting -> D, unless starve_cnt==STARVE_LIMIT, then I.
  - On the same edge: latch winner's addr/we/wdata into mem_address/mem_write_enable/mem_write_data; set mem_request=1, grant_owner=winner; go to ISSUE.
  - Request seen at edge k -> mem_request high from cycle k+1.
- Starve counter, updated at the grant edge:
  - D granted while i_req=1 -> increment, saturating at STARVE_LIMIT.
  - I granted -> clear to 0.
  - D granted with i_req=0 -> clear to 0.
- ISSUE:
  - Hold all mem_* outputs stable; requester inputs are ignored; a dropped req does not abort the transaction.
  - On mem_ready=1:
    - mem_request <= 0 and mem_write_enable <= 0.
    - For a read, owner's rdata <= mem_response_data; for a write, owner's rdata is unchanged.
    - owner's ready <= 1; go to RESP.
- RESP (exactly one cycle):
  - Owner's ready=1 this cycle only, then 0.
  - Requests are not sampled in RESP, so the owner's still-high req is not re-granted.
  - Go to IDLE. Earliest next grant is at the IDLE edge; back-to-back transactions cost 2 idle-side cycles.
- Non-owner ready stays 0 throughout. Non-owner rdata holds its last value.
- mem_ready while in IDLE or RESP is ignored.
- mem_ready on the first ISSUE cycle is legal and is treated as completion.
- rdata holds until the next read completion on the same port.
- arb_state reflects the registered state.

Test Plan:
- Reset then D read: d_req=1, d_addr=0x0000_1000, d_we=0 at edge 1 -> mem_request=1, mem_address=0x0000_1000, mem_write_enable=0 from cycle 2. Memory returns 0xDEAD_BEEF with mem_ready at edge 5 -> d_rdata=0xDEAD_BEEF, d_ready pulses for exactly 1 cycle, i_ready=0, arb_state returns to 0.
- I write: i_req=1, i_we=1, i_addr=0x40, i_wdata=0x1234_5678 -> mem_write_enable=1, mem_write_data=0x1234_5678. On completion i_ready pulses and i_rdata is unchanged (0).
- Simultaneous requests, STARVE_LIMIT=4: d_req and i_req held high continuously, memory ready after 1 cycle each -> grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt peaks at 4.
- Owner holds req during RESP: after d_ready, d_req stays high 1 extra cycle then drops -> no second D transaction issued; mem_request stays 0.
- Reset mid-ISSUE: assert rst while mem_request=1 -> next cycle mem_request=0, d_ready never pulses, state=IDLE, d_rdata=0.
- Stray mem_ready=1 in IDLE -> no ready pulse, rdata unchanged, state stays IDLE.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Shares one lower-memory port between the L1 D-cache (port d_*) and the
//   L1 I-cache (port i_*). Only one transaction is in flight at a time.
//   D has fixed priority. After STARVE_LIMIT consecutive D grants with I
//   waiting, the next contested grant goes to I.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready   D-cache side (level-held req)
//   i_req/i_we/i_addr/i_wdata -> i_rdata/i_ready   I-cache side (level-held req)
//   mem_request/mem_write_enable/mem_address/mem_write_data  lower-memory request
//   mem_response_data/mem_ready                               lower-memory response
//   grant_owner        current/last owner (0=D, 1=I)
//   arb_state          0=IDLE, 1=ISSUE, 2=RESP
//
// All outputs are registered.
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic                  mem_request,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_response_data,
    input  logic                  mem_ready,
    output logic                  grant_owner,
    output logic [1:0]            arb_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       pick_i;

    // I wins when it is the only requester, or when D has starved it long enough.
    always_comb begin
        pick_i = i_req && (!d_req || (starve_cnt == LIMIT));
    end

    assign arb_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            grant_owner      <= 1'b0;
            mem_request      <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            d_rdata          <= '0;
            d_ready          <= 1'b0;
            i_rdata          <= '0;
            i_ready          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || i_req) begin
                        grant_owner      <= pick_i;
                        mem_request      <= 1'b1;
                        mem_write_enable <= pick_i ? i_we    : d_we;
                        mem_address      <= pick_i ? i_addr  : d_addr;
                        mem_write_data   <= pick_i ? i_wdata : d_wdata;
                        // Counter only advances while I is actually being passed over.
                        if (pick_i || !i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_request      <= 1'b0;
                        mem_write_enable <= 1'b0;
                        // mem_write_enable still holds the in-flight direction here.
                        if (grant_owner) begin
                            i_ready <= 1'b1;
                            if (!mem_write_enable) begin
                                i_rdata <= mem_response_data;
                            end
                        end else begin
                            d_ready <= 1'b1;
                            if (!mem_write_enable) begin
                                d_rdata <= mem_response_data;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here so the owner's
                    // still-high req is not mistaken for a new transaction.
                    d_ready <= 1'b0;
                    i_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter
//   Self-checking bench for l1_mem_arbiter. Expected transactions are queued
//   when a request is driven and popped when the arbiter issues them to memory.
module tb_l1_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we, i_req, i_we;
    logic [31:0] d_addr, d_wdata, i_addr, i_wdata;
    logic [31:0] d_rdata, i_rdata;
    logic        d_ready, i_ready;
    logic        mem_request, mem_write_enable;
    logic [31:0] mem_address, mem_write_data, mem_response_data;
    logic        mem_ready;
    logic        grant_owner;
    logic [1:0]  arb_state;

    always #5 clk = ~clk;

    l1_mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_rdata          (d_rdata),
        .d_ready          (d_ready),
        .i_req            (i_req),
        .i_we             (i_we),
        .i_addr           (i_addr),
        .i_wdata          (i_wdata),
        .i_rdata          (i_rdata),
        .i_ready          (i_ready),
        .mem_request      (mem_request),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_response_data(mem_response_data),
        .mem_ready        (mem_ready),
        .grant_owner      (grant_owner),
        .arb_state        (arb_state)
    );

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
    } txn_t;

    txn_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_d_rdata = '0;
    logic [31:0] exp_i_rdata = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic push_txn(input logic owner, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rsp);
        txn_t t;
        t.owner = owner; t.we = we; t.addr = addr; t.wdata = wdata; t.rsp = rsp;
        exp_q.push_back(t);
    endtask

    task automatic wait_mem_req(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (mem_request) begin
                n  = c;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("mem_request_timeout", 64'd0, 64'd1);
    endtask

    // Waits for the next issue, compares it with the queue head, answers after
    // lat cycles and checks the completion. Returns at the RESP-cycle negedge.
    task automatic serve(input int lat, input int exp_gap);
        int   n;
        bit   ok;
        txn_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        wait_mem_req(n, ok);
        e = exp_q.pop_front();
        if (!ok) return;
        check("issue_gap", 64'(n), 64'(exp_gap));
        check("grant_owner", 64'(grant_owner), 64'(e.owner));
        check("mem_address", 64'(mem_address), 64'(e.addr));
        check("mem_write_enable", 64'(mem_write_enable), 64'(e.we));
        if (e.we) check("mem_write_data", 64'(mem_write_data), 64'(e.wdata));
        check("state_issue", 64'(arb_state), 64'd1);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("hold_request", 64'(mem_request), 64'd1);
            check("hold_address", 64'(mem_address), 64'(e.addr));
        end
        mem_response_data = e.rsp;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_response_data = $urandom;
        if (!e.we) begin
            if (e.owner) exp_i_rdata = e.rsp;
            else         exp_d_rdata = e.rsp;
        end
        check("d_ready_pulse", 64'(d_ready), 64'(!e.owner));
        check("i_ready_pulse", 64'(i_ready), 64'(e.owner));
        check("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
        check("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
        check("mem_request_drop", 64'(mem_request), 64'd0);
        check("state_resp", 64'(arb_state), 64'd2);
    endtask

    // Requester drops req after seeing ready; nothing further may be issued.
    task automatic finish_txn();
        @(negedge clk);
        d_req = 1'b0;
        i_req = 1'b0;
        check("ready_low_after", 64'({d_ready, i_ready}), 64'd0);
        check("state_idle_after", 64'(arb_state), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_reissue", 64'(mem_request), 64'd0);
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        logic own_seq [10];

        rst = 1'b1;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
        mem_ready = 0; mem_response_data = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 64'({mem_request, mem_write_enable, d_ready, i_ready, grant_owner, arb_state}), 64'd0);
        check("rst_rdata", 64'(d_rdata | i_rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_address | mem_write_data), 64'd0);
        rst = 1'b0;

        // D read, memory answers after a few cycles
        d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
        push_txn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF);
        serve(3, 1);
        finish_txn();

        // I write: i_rdata must stay 0
        i_req = 1; i_we = 1; i_addr = 32'h40; i_wdata = 32'h1234_5678;
        push_txn(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h5555_AAAA);
        serve(1, 1);
        finish_txn();

        // D read with mem_ready on the first ISSUE cycle; req held through RESP
        d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
        push_txn(1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D);
        serve(0, 1);
        finish_txn();

        // Contention: both held high, starvation limit 4
        own_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        d_req = 1; d_we = 0; d_addr = 32'h0000_3000;
        i_req = 1; i_we = 0; i_addr = 32'h0000_4000;
        for (int k = 0; k < 10; k++) begin
            push_txn(own_seq[k], 1'b0, own_seq[k] ? 32'h0000_4000 : 32'h0000_3000,
                     32'h0, 32'hA000_0000 + 32'(k));
        end
        for (int k = 0; k < 10; k++) begin
            serve(0, (k == 0) ? 1 : 2);
        end
        finish_txn();

        // Reset while a transaction is in ISSUE
        d_req = 1; d_we = 0; d_addr = 32'h0000_5000;
        wait_mem_req(n, ok);
        check("mid_issue_req", 64'(mem_request), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_request", 64'(mem_request), 64'd0);
        check("rst_mid_state", 64'(arb_state), 64'd0);
        check("rst_mid_d_ready", 64'(d_ready), 64'd0);
        check("rst_mid_d_rdata", 64'(d_rdata), 64'd0);
        check("rst_mid_i_rdata", 64'(i_rdata), 64'd0);
        rst = 1'b0;
        d_req = 1'b0;
        exp_d_rdata = '0;
        exp_i_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_ready", 64'({d_ready, i_ready, mem_request}), 64'd0);
        end

        // Load a known rdata, then stray mem_ready in IDLE must be ignored
        d_req = 1; d_we = 0; d_addr = 32'h0000_6000;
        push_txn(1'b0, 1'b0, 32'h0000_6000, 32'h0, 32'h0BAD_F00D);
        serve(2, 1);
        finish_txn();
        mem_response_data = 32'h9999_9999;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_state", 64'(arb_state), 64'd0);
            check("stray_ready", 64'({d_ready, i_ready, mem_request}), 64'd0);
            check("stray_d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
            check("stray_i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
        end
        mem_ready = 1'b0;

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
